ifu: RTL and testbench

Instruction fetch unit for the single-issue integer core. It sits directly upstream of the integer execution unit: it owns the program counter and fetches 32-bit words from instruction memory over a req/ack handshake. It presents each word with its PC and PC+4 to the execution unit, then advances, holds or redirects according to the execution unit's `stall`, `je` and `ja`. When no valid word is available, it inserts a NOP bubble.

---
 rtl/core_pkg.sv | 13 +
 rtl/ifu_if.sv | 23 ++
 rtl/ifu.sv | 102 ++++++++++
 tb/tb_ifu.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: NOP encoding and the fetch-unit state type.
package core_pkg;

    // addi x0,x0,0 with the implicit 2'b11 low bits stripped
    localparam logic [31:2] NOP_INSTR = 30'h0000_0004;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        EXEC
    } ifu_state_t;

endpackage

// File: rtl/ifu_if.sv
// Instruction memory request/ack bus between the fetch unit and imem.
interface ifu_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches over req/ack, presents
// instr/curr_pc/inc_pc to execute and inserts NOP bubbles on memory waits.
module ifu
    import core_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            je,
    input  logic [XLEN-1:0] ja,
    output logic [31:2]     instr,
    output logic [XLEN-1:0] curr_pc,
    output logic [XLEN-1:0] inc_pc,
    ifu_if.master           imem
);

    ifu_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:2]     instr_q, instr_d;
    logic [XLEN-1:0] curr_pc_q, curr_pc_d;
    logic [XLEN-1:0] inc_pc_q, inc_pc_d;

    logic [XLEN-1:0] tgt;
    logic            redirect;
    logic            req;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] addr_inc;

    // Low bits of the target and fetched word are architecturally ignored
    logic unused_bits;
    assign unused_bits = ^{ja[1:0], imem.imem_rdata[1:0]};

    // Request/address decode; depends combinationally on stall/je from execute
    always_comb begin
        tgt      = {ja[XLEN-1:2], 2'b00};
        redirect = (state_q == EXEC) && !stall && je;
        req      = (state_q == FETCH) || ((state_q == EXEC) && !stall);
        addr     = redirect ? tgt : pc_q;
        addr_inc = addr + XLEN'(4);
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;

    // Next-state: in FETCH, addr equals pc_q and curr_pc/inc_pc already
    // reflect it, so FETCH and an unstalled EXEC share one update path.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        curr_pc_d = curr_pc_q;
        inc_pc_d  = inc_pc_q;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH, EXEC: begin
                if (req) begin
                    curr_pc_d = addr;
                    inc_pc_d  = addr_inc;
                    if (imem.imem_ack) begin
                        instr_d = imem.imem_rdata[31:2];
                        pc_d    = addr_inc;
                        state_d = EXEC;
                    end else begin
                        instr_d = NOP_INSTR;
                        pc_d    = addr;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            instr_q   <= NOP_INSTR;
            curr_pc_q <= RESET_VECTOR;
            inc_pc_q  <= RESET_VECTOR + XLEN'(4);
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            curr_pc_q <= curr_pc_d;
            inc_pc_q  <= inc_pc_d;
        end
    end

    assign instr   = instr_q;
    assign curr_pc = curr_pc_q;
    assign inc_pc  = inc_pc_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, zero-wait fetch, jump, stall, wait states,
// PC wrap and asynchronous reset during an outstanding fetch.
module tb_ifu;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        je;
    logic [31:0] ja;
    logic [31:2] instr;
    logic [31:0] curr_pc;
    logic [31:0] inc_pc;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_if #(.XLEN(32)) imem_bus ();

    ifu #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0080)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .je      (je),
        .ja      (ja),
        .instr   (instr),
        .curr_pc (curr_pc),
        .inc_pc  (inc_pc),
        .imem    (imem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_curr, input logic [31:0] e_inc);
        chk({tag, ".instr"}, {2'b00, instr}, e_instr);
        chk({tag, ".curr_pc"}, curr_pc, e_curr);
        chk({tag, ".inc_pc"}, inc_pc, e_inc);
    endtask

    initial begin
        rst_n               = 1'b0;
        stall               = 1'b0;
        je                  = 1'b0;
        ja                  = 32'h0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk_regs("reset", 32'h4, 32'h80, 32'h84);
        chk("reset.req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("reset.addr", imem_bus.imem_addr, 32'h80);
        rst_n = 1'b1;
        #1;
        chk("boot.req", {31'd0, imem_bus.imem_req}, 32'd0);

        // FETCH of reset vector
        step();
        chk("fetch0.req", {31'd0, imem_bus.imem_req}, 32'd1);
        chk("fetch0.addr", imem_bus.imem_addr, 32'h80);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h00A0_0513;
        step();
        chk_regs("exec80", 32'h0028_0144, 32'h80, 32'h84);

        // Zero-bubble jump to 0
        je = 1'b1; ja = 32'h0;
        imem_bus.imem_rdata = 32'h0050_0093;
        #1;
        chk("jmp0.addr", imem_bus.imem_addr, 32'h0);
        chk("jmp0.req", {31'd0, imem_bus.imem_req}, 32'd1);
        step();
        chk_regs("line0", 32'h0014_0024, 32'h0, 32'h4);

        // Zero-wait straight line: 0, 4, 8
        je = 1'b0;
        imem_bus.imem_rdata = 32'h0010_8113;
        #1;
        chk("line4.addr", imem_bus.imem_addr, 32'h4);
        step();
        chk_regs("line4", 32'h0004_2044, 32'h4, 32'h8);
        imem_bus.imem_rdata = 32'h0021_0193;
        #1;
        chk("line8.addr", imem_bus.imem_addr, 32'h8);
        step();
        chk_regs("line8", 32'h0008_4064, 32'h8, 32'hC);

        // Stall with je asserted: everything holds, no redirect
        stall = 1'b1; je = 1'b1; ja = 32'h40;
        imem_bus.imem_ack = 1'b0;
        #1;
        chk("stall0.req", {31'd0, imem_bus.imem_req}, 32'd0);
        step();
        chk_regs("stall1", 32'h0008_4064, 32'h8, 32'hC);
        chk("stall1.req", {31'd0, imem_bus.imem_req}, 32'd0);
        step();
        chk_regs("stall2", 32'h0008_4064, 32'h8, 32'hC);
        stall = 1'b0; je = 1'b0;
        #1;
        chk("unstall.addr", imem_bus.imem_addr, 32'hC);
        chk("unstall.req", {31'd0, imem_bus.imem_req}, 32'd1);

        // Jump to misaligned target: low bits dropped
        je = 1'b1; ja = 32'h103;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("jmp100.addr", imem_bus.imem_addr, 32'h100);
        step();
        chk_regs("jmp100", 32'h37AB_6FBB, 32'h100, 32'h104);

        // Jump to 4 with three wait cycles
        je = 1'b1; ja = 32'h4;
        imem_bus.imem_ack = 1'b0;
        #1;
        chk("wait0.addr", imem_bus.imem_addr, 32'h4);
        step();
        je = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("wait%0d.addr", i), imem_bus.imem_addr, 32'h4);
            chk($sformatf("wait%0d.req", i), {31'd0, imem_bus.imem_req}, 32'd1);
            chk($sformatf("wait%0d.instr", i), {2'b00, instr}, 32'h4);
            if (i < 3) step();
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5677;
        step();
        chk_regs("wait.done", 32'h048D_159D, 32'h4, 32'h8);

        // Wrap from 0xFFFF_FFFC to 0
        je = 1'b1; ja = 32'hFFFF_FFFC;
        imem_bus.imem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("wrap.jaddr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk_regs("wrap.top", 32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0);
        je = 1'b0;
        imem_bus.imem_rdata = 32'h0000_0093;
        #1;
        chk("wrap.addr", imem_bus.imem_addr, 32'h0);
        step();
        chk_regs("wrap.zero", 32'h24, 32'h0, 32'h4);

        // Asynchronous reset during an unacked fetch
        imem_bus.imem_ack = 1'b0;
        step();
        chk("midrst.req", {31'd0, imem_bus.imem_req}, 32'd1);
        chk("midrst.addr", imem_bus.imem_addr, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.reqdrop", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("midrst.addrrv", imem_bus.imem_addr, 32'h80);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hCAFE_F00F;
        step();
        chk_regs("inrst", 32'h4, 32'h80, 32'h84);
        rst_n = 1'b1;
        imem_bus.imem_ack = 1'b0;
        #1;
        chk("reboot.req", {31'd0, imem_bus.imem_req}, 32'd0);
        step();
        chk("refetch.req", {31'd0, imem_bus.imem_req}, 32'd1);
        chk("refetch.addr", imem_bus.imem_addr, 32'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
